// File: rtl/sb_trans_scheduler.sv
// Sideband transaction scheduler: fixed-priority issue to the SB generator.
// SB_AT_RETRY_EN adds AT response tracking with timeout and retry.
module sb_trans_scheduler #(
  parameter int GAP_CYCLES  = 16,
  parameter int RSP_TIMEOUT = 4096,
  parameter int MAX_RETRY   = 2
) (
  input  logic       sb_clk,
  input  logic       rst,
  input  logic       lt_req,
  input  logic       at_cmd_req,
  input  logic [7:0] at_cmd_addr,
  input  logic       at_rsp_req,
  input  logic [7:0] at_rsp_addr,
  input  logic       at_rsp_rcvd,
  input  logic       trans_sent,
  input  logic       disconnected_s,
  output logic [2:0] trans_sel,
  output logic [7:0] control_unit_data,
  output logic       lt_done,
  output logic       at_rsp_done,
  output logic       at_cmd_done,
  output logic       at_cmd_err,
  output logic       busy
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  localparam logic [2:0] SEL_NONE = 3'd0;
  localparam logic [2:0] SEL_CMD  = 3'd2;
  localparam logic [2:0] SEL_RSP  = 3'd3;
  localparam logic [2:0] SEL_LT   = 3'd4;

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST =
    GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  logic [1:0]    state, state_n;
  logic [2:0]    cur, cur_n, win;
  logic          p_lt, p_lt_n;
  logic          p_cmd, p_cmd_n;
  logic          p_rsp, p_rsp_n;
  logic [7:0]    cmd_addr, cmd_addr_n;
  logic [7:0]    rsp_addr, rsp_addr_n;
  logic [GW-1:0] gap_cnt, gap_cnt_n;
  logic [2:0]    sel_n;
  logic [7:0]    data_n;
  logic          busy_n;
  logic          sent_ev, disc_ev;
  logic          clr_lt, clr_cmd, clr_rsp;
  logic          acc_cmd, acc_rsp;
  logic          cmd_blk, retry_set;
  logic          cmd_done_n, cmd_err_n;

  assign sent_ev = (state == S_WAIT) && trans_sent;
  assign disc_ev = disconnected_s &&
    ((state == S_ISSUE) || ((state == S_WAIT) && !trans_sent));
  assign clr_lt  = sent_ev && (cur == SEL_LT);
  assign clr_cmd = sent_ev && (cur == SEL_CMD);
  assign clr_rsp = sent_ev && (cur == SEL_RSP);

`ifdef SB_AT_RETRY_EN
  localparam int TW = $clog2(RSP_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(RSP_TIMEOUT - 1);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  logic          wait_act, wait_act_n;
  logic [TW-1:0] to_cnt, to_cnt_n;
  logic [RW-1:0] retry, retry_n;

  // A command whose send is completing already owns the response wait.
  always_comb begin
    wait_act_n = wait_act;
    to_cnt_n   = to_cnt;
    retry_n    = retry;
    retry_set  = 1'b0;
    cmd_done_n = 1'b0;
    cmd_err_n  = 1'b0;
    cmd_blk    = wait_act || clr_cmd;
    if (clr_cmd) begin
      wait_act_n = 1'b1;
      to_cnt_n   = '0;
    end else if (wait_act) begin
      if (at_rsp_rcvd) begin
        cmd_done_n = 1'b1;
        wait_act_n = 1'b0;
        retry_n    = '0;
      end else if (disc_ev) begin
        cmd_err_n  = 1'b1;
        wait_act_n = 1'b0;
        retry_n    = '0;
      end else if (to_cnt == TO_LAST) begin
        wait_act_n = 1'b0;
        if (retry < RETRY_MAX) begin
          retry_set = 1'b1;
          retry_n   = retry + 1'b1;
        end else begin
          cmd_err_n = 1'b1;
          retry_n   = '0;
        end
      end else begin
        to_cnt_n = to_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge sb_clk or negedge rst) begin
    if (!rst) begin
      wait_act <= 1'b0;
      to_cnt   <= '0;
      retry    <= '0;
    end else begin
      wait_act <= wait_act_n;
      to_cnt   <= to_cnt_n;
      retry    <= retry_n;
    end
  end
`else
  logic unused_rsp;
  assign unused_rsp = at_rsp_rcvd ^ (RSP_TIMEOUT == 0) ^ (MAX_RETRY == 0);
  assign cmd_blk    = 1'b0;
  assign retry_set  = 1'b0;
  assign cmd_done_n = clr_cmd;
  assign cmd_err_n  = 1'b0;
`endif

  always_comb begin
    acc_cmd = at_cmd_req && (!p_cmd || clr_cmd) && !cmd_blk;
    acc_rsp = at_rsp_req && (!p_rsp || clr_rsp);
    p_lt_n  = lt_req | (p_lt & ~clr_lt);
    p_rsp_n = acc_rsp | (p_rsp & ~clr_rsp);
    p_cmd_n = acc_cmd | retry_set | (p_cmd & ~clr_cmd);
    rsp_addr_n = acc_rsp ? at_rsp_addr : rsp_addr;
    cmd_addr_n = acc_cmd ? at_cmd_addr : cmd_addr;
    if (p_rsp)     win = SEL_RSP;
    else if (p_lt) win = SEL_LT;
    else           win = SEL_CMD;
  end

  always_comb begin
    state_n   = state;
    cur_n     = cur;
    gap_cnt_n = gap_cnt;
    sel_n     = SEL_NONE;
    data_n    = control_unit_data;
    unique case (state)
      S_IDLE: begin
        if ((p_lt | p_cmd | p_rsp) && !disconnected_s) begin
          state_n = S_ISSUE;
          cur_n   = win;
          sel_n   = win;
          if (win == SEL_RSP)      data_n = rsp_addr;
          else if (win == SEL_CMD) data_n = cmd_addr;
          else                     data_n = 8'h00;
        end
      end
      S_ISSUE: state_n = disconnected_s ? S_IDLE : S_WAIT;
      S_WAIT: begin
        if (trans_sent) begin
          state_n   = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
          gap_cnt_n = '0;
        end else if (disconnected_s) begin
          state_n = S_IDLE;
        end
      end
      S_GAP: begin
        if (gap_cnt == GAP_LAST) state_n = S_IDLE;
        else gap_cnt_n = gap_cnt + 1'b1;
      end
      default: state_n = S_IDLE;
    endcase
    busy_n = (state_n != S_IDLE) | p_lt_n | p_cmd_n | p_rsp_n;
  end

  always_ff @(posedge sb_clk or negedge rst) begin
    if (!rst) begin
      state             <= S_IDLE;
      cur               <= SEL_NONE;
      p_lt              <= 1'b0;
      p_cmd             <= 1'b0;
      p_rsp             <= 1'b0;
      cmd_addr          <= 8'h00;
      rsp_addr          <= 8'h00;
      gap_cnt           <= '0;
      trans_sel         <= SEL_NONE;
      control_unit_data <= 8'h00;
      lt_done           <= 1'b0;
      at_rsp_done       <= 1'b0;
      at_cmd_done       <= 1'b0;
      at_cmd_err        <= 1'b0;
      busy              <= 1'b0;
    end else begin
      state             <= state_n;
      cur               <= cur_n;
      p_lt              <= p_lt_n;
      p_cmd             <= p_cmd_n;
      p_rsp             <= p_rsp_n;
      cmd_addr          <= cmd_addr_n;
      rsp_addr          <= rsp_addr_n;
      gap_cnt           <= gap_cnt_n;
      trans_sel         <= sel_n;
      control_unit_data <= data_n;
      lt_done           <= clr_lt;
      at_rsp_done       <= clr_rsp;
      at_cmd_done       <= cmd_done_n;
      at_cmd_err        <= cmd_err_n;
      busy              <= busy_n;
    end
  end

endmodule

// File: doc/sb_trans_scheduler.md
# sb_trans_scheduler

Sideband transaction scheduler in front of the SB transactions generator FSM. Accepts one-cycle requests from three requesters (LT, AT command, AT response), holds each in a one-deep pending slot, and arbitrates by fixed priority. Issues one `trans_sel` pulse per transaction and drives the generator's `control_unit_data` until `trans_sent`. Enforces an inter-transaction gap and tracks AT command responses with timeout and retry.

## Interface
- `GAP_CYCLES`, 16: idle `sb_clk` cycles between `trans_sent` and the next issue; 0 disables the gap.
- `RSP_TIMEOUT`, 4096: cycles to wait for an AT response after an AT command is sent.
- `MAX_RETRY`, 2: AT command re-issues after timeout before error.

Ports:
- `sb_clk`  in  1  sideband clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `lt_req`  in  1  one-cycle request for an LT (LSE/CLSE) transaction.
- `at_cmd_req`  in  1  one-cycle request for an AT read command.
- `at_cmd_addr`  in  8  AT command address, sampled with `at_cmd_req`.
- `at_rsp_req`  in  1  one-cycle request for an AT read response.
- `at_rsp_addr`  in  8  AT response address, sampled with `at_rsp_req`.
- `at_rsp_rcvd`  in  1  pulse from the SB receiver: AT response received.
- `trans_sent`  in  1  generator completion pulse.
- `disconnected_s`  in  1  generator is in the DISCONNECT state.
- `trans_sel`  out  3  to generator: 0 none, 2 AT command, 3 AT response, 4 LT.
- `control_unit_data`  out  8  to generator: address byte of the active transaction.
- `lt_done`, `at_rsp_done`, `at_cmd_done`  out  1 each  completion pulses.
- `at_cmd_err`  out  1  pulse: AT command exhausted its retries, or the response wait was aborted.
- `busy`  out  1  high in any state other than IDLE, or while any slot is pending.

## Operation
- **Pending slots.** One slot each for `p_lt`, `p_cmd`, `p_rsp`. A request sets its slot and latches its address.
  - A request arriving while its slot is set is ignored. This includes `at_cmd_req` while a response wait is outstanding.
  - A request arriving in the same cycle its slot clears is accepted.
- **Priority.** `p_rsp` > `p_lt` > `p_cmd`, fixed.
- **FSM states:**
  - IDLE: if any slot is pending and `disconnected_s`=0, latch the winner and go to ISSUE.
  - ISSUE: drive `trans_sel` with the winner's code for exactly this one cycle, then go to WAIT_SENT.
  - WAIT_SENT: hold `trans_sel`=0 and `control_unit_data` stable. On `trans_sent`, clear the winner's slot and go to GAP. If `GAP_CYCLES`=0, go directly to IDLE.
  - GAP: count `GAP_CYCLES`, then go to IDLE.
- **`control_unit_data`.**
  - AT command or response: the latched address, valid from the ISSUE cycle until `trans_sent`.
  - LT: 8'h00.
  - IDLE: holds its last value.
- **Completion.**
  - `lt_done` / `at_rsp_done` pulse one cycle after their `trans_sent`.
  - An AT command's `trans_sent` starts the response wait (see Configuration).
- **Disconnect.** `disconnected_s` high in ISSUE or WAIT_SENT returns the FSM to IDLE.
  - The winner's slot stays set, so it is re-issued after reconnect.
  - Any outstanding response wait is aborted: `at_cmd_err` pulses, retry count clears.
- **Simultaneous events.**
  - `trans_sent` with `disconnected_s`: `trans_sent` wins; the transaction counts as complete.
  - `at_rsp_rcvd` in the timeout cycle: `at_rsp_rcvd` wins.
- **Spurious inputs.** `at_rsp_rcvd` with no wait outstanding is ignored. `trans_sent` outside WAIT_SENT is ignored.

## Timing
- **Reset values:** `trans_sel`=0, `control_unit_data`=0, all done/err pulses 0, `busy`=0; FSM in IDLE, slots, counters and retry count cleared.
- All outputs are registered.
- **Issue latency:**
  - Request at cycle N in IDLE (gap expired): slot set at N+1, FSM in ISSUE at N+2, `trans_sel` valid during N+2.
  - Minimum `trans_sent` → next `trans_sel` pulse: `GAP_CYCLES`+2 cycles.
- **Response timeout:** counter starts the cycle after `trans_sent`; the timeout fires when the count reaches `RSP_TIMEOUT`-1.

## Configuration
- Macro: `SB_AT_RETRY_EN`.
- **Defined:**
  - After an AT command's `trans_sent`, wait for `at_rsp_rcvd`. On receipt, pulse `at_cmd_done`.
  - On timeout with retry count < `MAX_RETRY`: set `p_cmd` again (same address) and increment the retry count.
  - Otherwise: pulse `at_cmd_err` and clear the wait.
- **Undefined:**
  - `at_cmd_done` pulses one cycle after the command's `trans_sent`.
  - `at_rsp_rcvd` is ignored and `at_cmd_err` is tied to 0. `at_cmd_err` also stays 0 on disconnect.
  - No response timer or retry logic is present.

## Test plan
- **Priority.** `lt_req`, `at_cmd_req` (addr 8'h0C) and `at_rsp_req` (addr 8'h0D) in the same cycle → `trans_sel` pulses 3, then 4, then 2. Data 8'h0D, 8'h00, 8'h0C. Each pulse is 1 cycle; consecutive pulses are ≥ `GAP_CYCLES`+2 apart.
- **Single-cycle pulse.** `trans_sel` is exactly 1 cycle wide, and `control_unit_data` is stable until `trans_sent`.
- **Timeout and retry.** With `SB_AT_RETRY_EN`, `RSP_TIMEOUT`=64, `MAX_RETRY`=2, AT command 8'h0C with no `at_rsp_rcvd` → 3 total `trans_sel`=2 issues, then one `at_cmd_err` pulse. The same test with `at_rsp_rcvd` after the first send → one `at_cmd_done`, no retry.
- **Disconnect mid-transaction.** `disconnected_s` asserted in WAIT_SENT of an LT → FSM to IDLE, no `lt_done`. After deassertion, `trans_sel`=4 is re-issued and `lt_done` follows `trans_sent`.
- **Duplicate request.** Second `lt_req` while `p_lt` is set → only one LT issued. `lt_req` in the same cycle as its `trans_sent` → a second LT is issued.
- **Reset mid-operation.** `rst` low during GAP → all outputs 0 immediately. No issue occurs until a new request arrives.
